// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses stall the CPU while the
// controller optionally writes back a dirty victim and then fetches the block.
//
// state     | meaning
// IDLE      | serving hits, detecting misses
// WRITEBACK | writing dirty victim block to memory
// ALLOCATE  | fetching requested block from memory
module dcache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic [31:0]           cpu_rdata_o,
  output logic                  cpu_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int WOFF_W = OFF_W - 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WOFF_W-1:0] cpu_woff;
  logic              hit;
  logic              store_hit;
  logic              fill;
  logic              victim_dirty;
  logic [31:0]       line_word;
  logic              unused_addr_bits;

  assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
  assign cpu_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_woff         = cpu_addr_i[2 +: WOFF_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit          = cpu_req_i && (state_q == IDLE) && valid_q[cpu_idx] &&
                        (tag_q[cpu_idx] == cpu_tag);
  assign store_hit    = hit && cpu_we_i;
  assign fill         = (state_q == ALLOCATE) && mem_ack_i;
  assign victim_dirty = valid_q[cpu_idx] && dirty_q[cpu_idx];
  assign line_word    = data_q[cpu_idx][{cpu_woff, 5'b0} +: 32];

  // CPU-facing outputs: zero-cycle hits, stall on any miss or refill activity
  assign cpu_rdata_o = (hit && !cpu_we_i) ? line_word : 32'h0;
  assign cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !hit);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Line status bits; reset invalidates everything and drops dirty data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[cpu_idx] <= 1'b1;
      dirty_q[cpu_idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[cpu_idx] <= 1'b1;
    end
  end

  // Tag and data storage, not reset; meaningful only while valid
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[cpu_idx]  <= cpu_tag;
      data_q[cpu_idx] <= mem_rdata_i;
    end else if (store_hit) begin
      data_q[cpu_idx][{cpu_woff, 5'b0} +: 32] <= cpu_wdata_i;
    end
  end

  // Next-state and memory-side outputs; held constant throughout each state
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[cpu_idx], cpu_idx, {OFF_W{1'b0}}};
        mem_wdata_o = data_q[cpu_idx];
        if (mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a behavioural block memory.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 3;
  int cnt      = 0;
  int wb_cnt   = 0;
  int al_cnt   = 0;
  logic [31:0]  wb_addr = '0;
  logic [31:0]  al_addr = '0;
  logic [255:0] wb_data = '0;

  logic [255:0] mem_blk [256];
  logic [255:0] wr_flag = '0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  // Unwritten blocks hold word w of block a = {a[27:0], w[3:0]}; block 0x40 word2 is preset
  function automatic logic [255:0] rd_block(input logic [31:0] a);
    logic [255:0] blk;
    if (wr_flag[a[12:5]]) return mem_blk[a[12:5]];
    for (int w = 0; w < 8; w++) blk[w*32 +: 32] = {a[27:0], w[3:0]};
    if (a == 32'h0000_0040) blk[95:64] = 32'h1234_5678;
    return blk;
  endfunction

  // Memory responder: each transaction lasts lat cycles, ack in the last one
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (mem_req && !mem_ack && !rst) begin
      if (cnt >= lat - 2) begin
        mem_ack <= 1'b1;
        cnt     <= 0;
        if (mem_we) begin
          wb_cnt                 <= wb_cnt + 1;
          wb_addr                <= mem_addr;
          wb_data                <= mem_wdata;
          mem_blk[mem_addr[12:5]] <= mem_wdata;
          wr_flag[mem_addr[12:5]] <= 1'b1;
        end else begin
          al_cnt    <= al_cnt + 1;
          al_addr   <= mem_addr;
          mem_rdata <= rd_block(mem_addr);
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an access and wait (bounded) until it completes without stall
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    stalls    = 0;
    rd        = '0;
    while (1) begin
      @(negedge clk);
      if (!cpu_stall) begin
        rd = cpu_rdata;
        break;
      end
      stalls++;
      if (stalls > 100) begin
        check("access_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input string tag, input logic [31:0] a, input logic [31:0] exp,
                       input int exp_st);
    logic [31:0] rd;
    int          st;
    access(1'b0, a, 32'h0, rd, st);
    check({tag, "_data"}, rd, exp);
    check({tag, "_stalls"}, 32'(st), 32'(exp_st));
  endtask

  task automatic do_st(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input int exp_st);
    logic [31:0] rd;
    int          st;
    access(1'b1, a, wd, rd, st);
    check({tag, "_rdata0"}, rd, 32'h0);
    check({tag, "_stalls"}, 32'(st), 32'(exp_st));
  endtask

  initial begin
    logic [31:0] rd;
    int          st;
    logic [31:0] exp;

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0040;
    #1;
    check("rst_req_stalls", {31'b0, cpu_stall}, 32'd1);
    check("rst_req_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;

    // cold miss, then hits within the fetched line
    lat = 3;
    do_ld("cold_ld_40", 32'h0000_0040, 32'h0000_0400, 4);
    check("cold_al_addr", al_addr, 32'h0000_0040);
    check("cold_wb_cnt", 32'(wb_cnt), 32'd0);
    do_ld("hit_ld_48", 32'h0000_0048, 32'h1234_5678, 0);
    do_st("st_hit_44", 32'h0000_0044, 32'hDEAD_BEEF, 0);
    do_ld("ld_44", 32'h0000_0044, 32'hDEAD_BEEF, 0);
    do_ld("ld_48_kept", 32'h0000_0048, 32'h1234_5678, 0);

    // dirty conflict miss: write-back then allocate
    do_ld("dirty_miss_444", 32'h0000_0444, 32'h0000_4401, 7);
    check("wb_cnt1", 32'(wb_cnt), 32'd1);
    check("wb_addr", wb_addr, 32'h0000_0040);
    check("wb_word1", wb_data[63:32], 32'hDEAD_BEEF);
    check("wb_word2", wb_data[95:64], 32'h1234_5678);
    check("al_addr_440", al_addr, 32'h0000_0440);

    // clean conflict miss with 10-cycle memory
    lat = 10;
    do_ld("clean_miss_840", 32'h0000_0840, 32'h0000_8400, 11);
    check("clean_wb_cnt", 32'(wb_cnt), 32'd1);
    check("al_addr_840", al_addr, 32'h0000_0840);

    // refetch of written-back line returns the stored word
    lat = 2;
    do_ld("refetch_44", 32'h0000_0044, 32'hDEAD_BEEF, 3);
    check("refetch_wb_cnt", 32'(wb_cnt), 32'd1);

    // store miss allocates then merges
    do_st("st_miss_c64", 32'h0000_0C64, 32'h1234_ABCD, 3);
    check("al_addr_c60", al_addr, 32'h0000_0C60);
    do_ld("ld_c64", 32'h0000_0C64, 32'h1234_ABCD, 0);

    // back-to-back hits across all words of the line
    for (int w = 0; w < 8; w++) begin
      exp = (w == 1) ? 32'h1234_ABCD : (32'h0000_C600 | 32'(w));
      do_ld($sformatf("b2b_w%0d", w), 32'h0000_0C60 + 32'(w * 4), exp, 0);
    end

    // no request: rdata must be zero even for a resident address
    cpu_req  = 1'b0;
    cpu_addr = 32'h0000_0C64;
    @(negedge clk);
    check("no_req_rdata", cpu_rdata, 32'h0);
    check("no_req_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;

    // reset during write-back coinciding with ack
    lat      = 4;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_1C64;
    st       = 0;
    while (1) begin
      @(negedge clk);
      if (mem_ack) break;
      st++;
      if (st > 50) begin
        check("rst_wb_ack_timeout", 32'(st), 32'd0);
        break;
      end
    end
    check("rst_wb_we", {31'b0, mem_we}, 32'd1);
    check("rst_wb_addr", mem_addr, 32'h0000_0C60);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("post_rst_stall", {31'b0, cpu_stall}, 32'd0);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0C64;
    #1;
    check("reload_misses", {31'b0, cpu_stall}, 32'd1);
    access(1'b0, 32'h0000_0C64, 32'h0, rd, st);
    check("reload_stalls", 32'(st), 32'd4);
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
